credit_flit_sender: RTL and testbench
=====================================

// Module: credit_flit_sender
// PURPOSE
//  Upstream (write-side) end of the credit-based link into a downstream input buffer.
//  Accepts flits from router-internal logic with a valid/ready handshake.
//  Forwards each flit as a one-cycle write strobe plus data to the downstream buffer.
//  Tracks free downstream slots with a credit counter, so the downstream buffer never sees a write while full.
// PARAMETERS
//  FLIT_SIZE   8  width of one flit in bits
//  BUFFER_SIZE 8  depth of the downstream buffer, which is the initial credit count; any value >= 2, not only powers of 2
//  CNT_W       derived, clogb2(BUFFER_SIZE+1); width of the credit counter. Not user-set.
// PORTS
//  clk           in   1          clock; all state updates on the rising edge
//  rst           in   1          asynchronous reset, active-low (0 = reset)
//  data_i        in   FLIT_SIZE  flit from upstream logic
//  valid_i       in   1          data_i holds a flit
//  ready_o       out  1          sender can accept a flit this cycle
//  credit_i      in   1          one pulse per flit read out of the downstream buffer
//  data_o        out  FLIT_SIZE  flit to the downstream buffer
//  valid_o       out  1          write strobe to the downstream buffer, high for exactly one cycle per flit
//  credit_cnt_o  out  CNT_W      current free downstream slots, 0..BUFFER_SIZE
//  error_o       out  1          sticky flag: a credit was returned while the counter was already at BUFFER_SIZE
// BEHAVIOUR
//  Reset (rst=0, asynchronous):
//   - credit_cnt_o = BUFFER_SIZE, valid_o = 0, data_o = 0, error_o = 0.
//   - Reset mid-burst drops any in-flight flit. Upstream and downstream are reset together.
//  Handshake:
//   - ready_o = (credit_cnt_o != 0), driven combinationally from the registered counter only.
//   - ready_o does not depend on valid_i or credit_i.
//   - A transfer occurs on a cycle with valid_i & ready_o.
//   - valid_i with ready_o=0 is a stall. Upstream holds data_i stable; nothing is sent.
//  Output latency: 1 cycle.
//   - Transfer in cycle N gives data_o = data_i(N) and valid_o = 1 in cycle N+1.
//   - No transfer gives valid_o = 0 in the next cycle; data_o holds its last value.
//   - Back-to-back transfers give a continuous valid_o, one flit per cycle.
//  Credit counter update each cycle, with t = transfer and c = credit_i:
//   - t=1, c=0: count - 1. This never underflows, because t requires count != 0.
//   - t=0, c=1: count + 1, or saturate at BUFFER_SIZE and set error_o if already full.
//   - t=1, c=1: unchanged. This applies even at BUFFER_SIZE, because the increment is absorbed; error_o is not set.
//   - t=0, c=0: unchanged.
//  No credit bypass:
//   - A credit arriving while count == 0 raises ready_o in the next cycle, not the same cycle.
//   - Minimum credit-to-send turnaround is 1 cycle.
//  Overflow:
//   - error_o is set only by the t=0, c=1, count == BUFFER_SIZE case.
//   - It stays set until reset. The counter never exceeds BUFFER_SIZE.
//  Arithmetic:
//   - Counter is unsigned CNT_W bits with no wrap-around.
//   - All comparisons are against BUFFER_SIZE as a CNT_W-bit constant.
// TESTING
//  1. Release rst, idle -> credit_cnt_o=8, ready_o=1, valid_o=0, error_o=0.
//  2. Send 8 flits 0x01..0x08 back-to-back, no credits:
//     -> valid_o high for cycles 2..9 with data_o 0x01..0x08;
//     -> credit_cnt_o counts 7..0; ready_o=0 after the 8th;
//     -> a 9th flit 0x09 held on data_i is not sent.
//  3. From count=0 with 0x09 pending, pulse credit_i for one cycle:
//     -> next cycle count=1, ready_o=1;
//     -> 0x09 transfers; one cycle later valid_o=1, data_o=0x09, count=0.
//  4. At count=3, assert a transfer and credit_i in the same cycle -> count stays 3; flit appears on data_o next cycle.
//  5. At count=8, credit_i=1 with no transfer -> count stays 8, error_o=1 and remains 1 over 20 further idle cycles.
//     At count=8, credit_i=1 with a transfer -> count 8, no error.
//  6. Assert rst mid-burst at count=4:
//     -> valid_o=0 immediately, without waiting for clk; count=8; error_o=0;
//     -> first flit after release is sent normally.
//     Repeat tests 2-3 with BUFFER_SIZE=5: exactly 5 sends before stall.

Source files
------------

// File: rtl/credit_flit_sender_if.sv
// Handshake and link signals of the credit-based flit sender.
// The slave view belongs to the sender. The master view belongs to whatever sits on both sides of it.
interface credit_flit_sender_if #(
  parameter int FLIT_SIZE = 8,
  parameter int CNT_W     = 4
);
  logic [FLIT_SIZE-1:0] data_i;
  logic                 valid_i;
  logic                 ready_o;
  logic                 credit_i;
  logic [FLIT_SIZE-1:0] data_o;
  logic                 valid_o;
  logic [CNT_W-1:0]     credit_cnt_o;
  logic                 error_o;

  modport slave (
    input  data_i, valid_i, credit_i,
    output ready_o, data_o, valid_o, credit_cnt_o, error_o
  );

  modport master (
    output data_i, valid_i, credit_i,
    input  ready_o, data_o, valid_o, credit_cnt_o, error_o
  );
endinterface

// File: rtl/credit_flit_sender.sv
// Upstream end of a credit-based link: forwards accepted flits as one-cycle write strobes
// and counts free downstream slots so the downstream buffer is never written while full.
module credit_flit_sender #(
  parameter int FLIT_SIZE   = 8,
  parameter int BUFFER_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  credit_flit_sender_if.slave  bus
);
  localparam int               CNT_W = $clog2(BUFFER_SIZE + 1);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(BUFFER_SIZE);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [FLIT_SIZE-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic                 ready;
  logic                 xfer;

  // ready comes only from the registered count, so a returning credit takes effect next cycle
  assign ready = (cnt_q != '0);
  assign xfer  = bus.valid_i & ready;

  always_comb begin
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = xfer;
    err_d   = err_q;
    if (xfer)
      data_d = bus.data_i;
    unique case ({xfer, bus.credit_i})
      2'b10: cnt_d = cnt_q - ONE;
      2'b01: begin
        if (cnt_q == FULL)
          err_d = 1'b1;
        else
          cnt_d = cnt_q + ONE;
      end
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= FULL;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign bus.ready_o      = ready;
  assign bus.data_o       = data_q;
  assign bus.valid_o      = valid_q;
  assign bus.credit_cnt_o = cnt_q;
  assign bus.error_o      = err_q;
endmodule

// File: tb/tb_credit_flit_sender.sv
// Drives two senders (depth 8 and depth 5) with the same stimulus.
// Each sender's output is compared with a credit-ledger model and a queue of expected flits.
module tb_credit_flit_sender;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  credit_flit_sender_if #(.FLIT_SIZE(8), .CNT_W(4)) bus0 ();
  credit_flit_sender_if #(.FLIT_SIZE(8), .CNT_W(3)) bus1 ();

  credit_flit_sender #(.FLIT_SIZE(8), .BUFFER_SIZE(8)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  credit_flit_sender #(.FLIT_SIZE(8), .BUFFER_SIZE(5)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int tests = 0;
  int fails = 0;

  int         bsz[2] = '{8, 5};
  int         mcnt[2];
  bit         merr[2];
  bit         mlast[2];
  logic [7:0] mdata[2];
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state(input int k, input int cnt, input bit rdy, input bit vld,
                             input logic [7:0] dat, input bit err);
    string p;
    p = (k == 0) ? "b8" : "b5";
    check({p, "_cnt"},   cnt, mcnt[k]);
    check({p, "_ready"}, int'(rdy), int'(mcnt[k] != 0));
    check({p, "_valid"}, int'(vld), int'(mlast[k]));
    check({p, "_error"}, int'(err), int'(merr[k]));
    if (!vld) check({p, "_hold"}, int'(dat), int'(mdata[k]));
  endtask

  task automatic model_step(input int k, input bit v, input logic [7:0] d, input bit c);
    bit t;
    t = v && (mcnt[k] != 0);
    mlast[k] = t;
    if (t) begin
      mdata[k] = d;
      if (k == 0) q0.push_back(d);
      else        q1.push_back(d);
    end
    if (t && !c)
      mcnt[k] = mcnt[k] - 1;
    else if (!t && c) begin
      if (mcnt[k] == bsz[k]) merr[k] = 1'b1;
      else                   mcnt[k] = mcnt[k] + 1;
    end
  endtask

  // called just after a rising edge; returns just after the next rising edge
  task automatic step(input bit v, input logic [7:0] d, input bit c);
    bus0.valid_i = v; bus0.data_i = d; bus0.credit_i = c;
    bus1.valid_i = v; bus1.data_i = d; bus1.credit_i = c;
    @(negedge clk);
    check_state(0, int'(bus0.credit_cnt_o), bus0.ready_o, bus0.valid_o, bus0.data_o, bus0.error_o);
    check_state(1, int'(bus1.credit_cnt_o), bus1.ready_o, bus1.valid_o, bus1.data_o, bus1.error_o);
    model_step(0, v, d, c);
    model_step(1, v, d, c);
    @(posedge clk);
    #1;
  endtask

  // asserted between clock edges so the asynchronous clear is observable before any edge
  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_b8_valid", int'(bus0.valid_o), 0);
    check("rst_b8_cnt",   int'(bus0.credit_cnt_o), 8);
    check("rst_b8_error", int'(bus0.error_o), 0);
    check("rst_b8_data",  int'(bus0.data_o), 0);
    check("rst_b5_valid", int'(bus1.valid_o), 0);
    check("rst_b5_cnt",   int'(bus1.credit_cnt_o), 5);
    check("rst_b5_error", int'(bus1.error_o), 0);
    for (int k = 0; k < 2; k++) begin
      mcnt[k]  = bsz[k];
      merr[k]  = 1'b0;
      mlast[k] = 1'b0;
      mdata[k] = 8'h00;
    end
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // data monitor: every write strobe must carry the oldest flit still owed
  always @(negedge clk) begin
    if (rst) begin
      if (bus0.valid_o) begin
        if (q0.size() == 0) check("b8_unexpected_write", 1, 0);
        else                check("b8_data", int'(bus0.data_o), int'(q0.pop_front()));
      end
      if (bus1.valid_o) begin
        if (q1.size() == 0) check("b5_unexpected_write", 1, 0);
        else                check("b5_data", int'(bus1.data_o), int'(q1.pop_front()));
      end
    end
  end

  initial begin
    logic [7:0] d;
    bit         v, c, pend;
    bus0.valid_i = 1'b0; bus0.data_i = 8'h00; bus0.credit_i = 1'b0;
    bus1.valid_i = 1'b0; bus1.data_i = 8'h00; bus1.credit_i = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // idle after reset
    step(0, 8'h00, 0);
    step(0, 8'h00, 0);

    // fill all credits, then a held flit stalls
    for (int i = 1; i <= 8; i++) step(1, 8'(i), 0);
    step(1, 8'h09, 0);
    step(1, 8'h09, 0);
    // one credit lets the held flit through a cycle later
    step(1, 8'h09, 1);
    step(1, 8'h09, 0);
    step(0, 8'h09, 0);
    step(0, 8'h00, 0);

    // transfer and credit together at count 3
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 8'(8'h20 + i), 0);
    step(1, 8'h5a, 1);
    step(0, 8'h00, 0);

    // at full: transfer with credit absorbs it, credit alone sets the sticky error
    do_reset();
    step(1, 8'h33, 1);
    step(0, 8'h00, 1);
    for (int i = 0; i < 20; i++) step(0, 8'h00, 0);

    // reset mid-burst, then a normal send
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 8'(8'h40 + i), 0);
    do_reset();
    step(1, 8'h77, 0);
    step(0, 8'h00, 0);

    // randomized traffic, data held stable while the deeper sender stalls
    pend = 1'b0;
    d    = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 499) begin
        do_reset();
        pend = 1'b0;
      end
      v = pend ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (!pend) d = 8'($urandom);
      c = ($urandom_range(0, 2) == 0);
      pend = v && (mcnt[0] == 0);
      step(v, d, c);
    end
    step(0, 8'h00, 0);
    step(0, 8'h00, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
